// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared types and sizes for the I2C master byte datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
    // Wide enough to hold DATA_W itself, not just DATA_W-1.
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TX     = 2'd1,
        ST_ACK_RX = 2'd2,
        ST_RX     = 2'd3
    } dp_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_master_datapath_filter.sv
// ============================================================================
// Module   : i2c_line_filter
// Brief    : Line conditioner for SDA/SCL feedback. Plain register by default;
//            3-sample majority vote when I2C_DP_SDA_FILTER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_line_filter (
    input  logic i2c_core_clk_i,
    input  logic reset_i,
    input  logic line_i,
    output logic line_o
);

    logic line_q;

`ifdef I2C_DP_SDA_FILTER_EN
    logic [2:0] samp_q;
    logic       maj_d;

    assign maj_d = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    // Resets to the idle-bus level so no spurious edge follows reset.
    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            samp_q <= 3'b111;
            line_q <= 1'b1;
        end else begin
            samp_q <= {samp_q[1:0], line_i};
            line_q <= maj_d;
        end
    end
`else
    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            line_q <= 1'b1;
        end else begin
            line_q <= line_i;
        end
    end
`endif

    assign line_o = line_q;

endmodule

`default_nettype wire

// File: rtl/i2c_master_datapath.sv
// ============================================================================
// Module   : i2c_master_datapath
// Brief    : I2C master byte datapath: address/data shift-out, slave ACK
//            capture, byte receive. Optional line filter: I2C_DP_SDA_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master_datapath
    import i2c_pkg::*;
#(
    parameter int DATA_W = i2c_pkg::DATA_W,
    parameter int ADDR_W = i2c_pkg::ADDR_W
) (
    input  logic              i2c_core_clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] slave_addr_i,
    input  logic              rw_i,
    input  logic              write_addr_en_i,
    input  logic              write_data_en_i,
    input  logic              receive_data_en_i,
    input  logic              sda_low_en_i,
    input  logic              i2c_sda_en_i,
    input  logic              i2c_scl_i,
    input  logic              i2c_sda_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_empty_i,
    output logic              tx_rd_en_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_wr_en_o,
    input  logic              rx_full_i,
    output logic              sda_pull_low_o,
    output logic              ack_o,
    output logic              ack_valid_o,
    output logic              underrun_o,
    output logic              overflow_o
);

    dp_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              drive_bit_q, drive_bit_d;
    logic              sda_pull_q, sda_pull_d;
    logic              ack_q, ack_d;
    logic              ack_valid_q, ack_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_wr_en_q, rx_wr_en_d;
    logic              underrun_q, underrun_d;
    logic              overflow_q, overflow_d;
    logic              scl_prev_q;

    logic              w_scl;
    logic              w_sda;
    logic              w_scl_rise;
    logic              w_tx_pop;
    logic              w_tx_pulse;

    i2c_line_filter u_scl_filter (
        .i2c_core_clk_i (i2c_core_clk_i),
        .reset_i        (reset_i),
        .line_i         (i2c_scl_i),
        .line_o         (w_scl)
    );

    i2c_line_filter u_sda_filter (
        .i2c_core_clk_i (i2c_core_clk_i),
        .reset_i        (reset_i),
        .line_i         (i2c_sda_i),
        .line_o         (w_sda)
    );

    assign w_scl_rise = w_scl & ~scl_prev_q;
    assign w_tx_pulse = write_addr_en_i | write_data_en_i;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        drive_bit_d = drive_bit_q;
        ack_d       = ack_q;
        ack_valid_d = 1'b0;
        rx_data_d   = rx_data_q;
        rx_wr_en_d  = 1'b0;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q;
        w_tx_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (write_addr_en_i) begin
                    shreg_d     = {slave_addr_i[ADDR_W-2:0], rw_i, 1'b0};
                    drive_bit_d = slave_addr_i[ADDR_W-1];
                    bit_cnt_d   = CNT_W'(DATA_W - 1);
                    state_d     = ST_TX;
                end else if (write_data_en_i) begin
                    if (!tx_empty_i) begin
                        w_tx_pop    = 1'b1;
                        shreg_d     = {tx_data_i[DATA_W-2:0], 1'b0};
                        drive_bit_d = tx_data_i[DATA_W-1];
                        bit_cnt_d   = CNT_W'(DATA_W - 1);
                        state_d     = ST_TX;
                    end else begin
                        underrun_d  = 1'b1;
                        drive_bit_d = 1'b1;
                    end
                end else if (receive_data_en_i) begin
                    bit_cnt_d = '0;
                    state_d   = ST_RX;
                end
            end
            ST_TX: begin
                if (w_tx_pulse) begin
                    if (bit_cnt_q == '0) begin
                        // Release SDA so the slave can drive its ACK bit.
                        drive_bit_d = 1'b1;
                        state_d     = ST_ACK_RX;
                    end else begin
                        drive_bit_d = shreg_q[DATA_W-1];
                        shreg_d     = {shreg_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d   = bit_cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_ACK_RX: begin
                if (w_scl_rise) begin
                    ack_d       = w_sda;
                    ack_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RX: begin
                if (w_scl_rise && receive_data_en_i) begin
                    shreg_d = {shreg_q[DATA_W-2:0], w_sda};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d = shreg_d;
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                        if (rx_full_i) begin
                            overflow_d = 1'b1;
                        end else begin
                            rx_wr_en_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Built from next-state values so the pin follows an enable pulse by one clock.
        sda_pull_d = sda_low_en_i | (i2c_sda_en_i & (state_d == ST_TX) & ~drive_bit_d);
    end

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            drive_bit_q <= 1'b1;
            sda_pull_q  <= 1'b0;
            ack_q       <= 1'b0;
            ack_valid_q <= 1'b0;
            rx_data_q   <= '0;
            rx_wr_en_q  <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            scl_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            drive_bit_q <= drive_bit_d;
            sda_pull_q  <= sda_pull_d;
            ack_q       <= ack_d;
            ack_valid_q <= ack_valid_d;
            rx_data_q   <= rx_data_d;
            rx_wr_en_q  <= rx_wr_en_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            scl_prev_q  <= w_scl;
        end
    end

    assign tx_rd_en_o     = w_tx_pop & ~reset_i;
    assign rx_data_o      = rx_data_q;
    assign rx_wr_en_o     = rx_wr_en_q;
    assign sda_pull_low_o = sda_pull_q;
    assign ack_o          = ack_q;
    assign ack_valid_o    = ack_valid_q;
    assign underrun_o     = underrun_q;
    assign overflow_o     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_datapath.sv
// ============================================================================
// Module   : tb_i2c_master_datapath
// Brief    : Self-checking bench for i2c_master_datapath (table vectors plus
//            hand-written reset/underrun/priority sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_datapath;

`ifdef I2C_DP_SDA_FILTER_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] slave_addr;
    logic       rw, wa_en, wd_en, rx_en, sda_low_en, sda_en, scl, sda;
    logic [7:0] tx_data;
    logic       tx_empty, rx_full;
    logic       tx_rd_en_o, rx_wr_en_o, sda_pull_low_o, ack_o, ack_valid_o;
    logic       underrun_o, overflow_o;
    logic [7:0] rx_data_o;

    int checks = 0;
    int errors = 0;
    int tx_pops = 0;
    int rx_pushes = 0;

    always #5 clk = ~clk;

    i2c_master_datapath dut (
        .i2c_core_clk_i    (clk),
        .reset_i           (rst),
        .slave_addr_i      (slave_addr),
        .rw_i              (rw),
        .write_addr_en_i   (wa_en),
        .write_data_en_i   (wd_en),
        .receive_data_en_i (rx_en),
        .sda_low_en_i      (sda_low_en),
        .i2c_sda_en_i      (sda_en),
        .i2c_scl_i         (scl),
        .i2c_sda_i         (sda),
        .tx_data_i         (tx_data),
        .tx_empty_i        (tx_empty),
        .tx_rd_en_o        (tx_rd_en_o),
        .rx_data_o         (rx_data_o),
        .rx_wr_en_o        (rx_wr_en_o),
        .rx_full_i         (rx_full),
        .sda_pull_low_o    (sda_pull_low_o),
        .ack_o             (ack_o),
        .ack_valid_o       (ack_valid_o),
        .underrun_o        (underrun_o),
        .overflow_o        (overflow_o)
    );

    always @(negedge clk) begin
        if (tx_rd_en_o) tx_pops++;
        if (rx_wr_en_o) rx_pushes++;
    end

    typedef struct {
        logic [7:0] data;
        logic       sda_en;
        logic [7:0] exp_pull;
        logic       ack_sda;
    } tx_vec_t;

    typedef struct {
        logic [7:0] pattern;
        logic [7:0] glitch;
        logic       full;
        logic [7:0] exp_data;
        int         exp_push;
        logic       exp_ovf;
    } rx_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Eight shift pulses (with an idle gap after each) then the ACK-release pulse.
    task automatic send_byte(input logic use_addr, input logic use_both,
                             input logic [7:0] exp_pull, input int exp_pops, input string tag);
        int pops0;
        pops0 = tx_pops;
        for (int i = 0; i < 9; i++) begin
            wa_en = use_addr | use_both;
            wd_en = ~use_addr | use_both;
            tick();
            wa_en = 1'b0;
            wd_en = 1'b0;
            if (i < 8) chk($sformatf("%s_pull_bit%0d", tag, i), sda_pull_low_o, exp_pull[7-i]);
            else       chk($sformatf("%s_pull_release", tag), sda_pull_low_o, 1'b0);
            tick();
        end
        chk($sformatf("%s_pops", tag), tx_pops - pops0, exp_pops);
    endtask

    task automatic ack_phase(input logic sda_v, input logic exp_ack, input string tag);
        sda = sda_v;
        scl = 1'b0;
        repeat (LAT + 1) tick();
        scl = 1'b1;
        repeat (LAT) tick();
        chk({tag, "_ackv_early"}, ack_valid_o, 1'b0);
        tick();
        chk({tag, "_ackv"}, ack_valid_o, 1'b1);
        chk({tag, "_ack"}, ack_o, exp_ack);
        tick();
        chk({tag, "_ackv_pulse"}, ack_valid_o, 1'b0);
        sda = 1'b1;
    endtask

    task automatic rx_byte(input rx_vec_t v, input string tag);
        int push0;
        push0   = rx_pushes;
        rx_full = v.full;
        rx_en   = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            sda = v.pattern[7-i];
            scl = 1'b0;
            repeat (LAT + 1) tick();
            scl = 1'b1;
            sda = v.glitch[7-i] ? ~v.pattern[7-i] : v.pattern[7-i];
            tick();
            sda = v.pattern[7-i];
            repeat (LAT - 1) tick();
            if (i == 7) chk({tag, "_push_early"}, rx_wr_en_o, 1'b0);
            tick();
        end
        rx_en = 1'b0;
        chk({tag, "_push"}, rx_wr_en_o, v.exp_push[0]);
        chk({tag, "_data"}, rx_data_o, v.exp_data);
        chk({tag, "_ovf"}, overflow_o, v.exp_ovf);
        tick();
        chk({tag, "_push_count"}, rx_pushes - push0, v.exp_push);
        sda = 1'b1;
    endtask

    tx_vec_t tx_tab[4];
    rx_vec_t rx_tab[4];

    initial begin
        tx_tab[0] = '{data: 8'hA5, sda_en: 1'b1, exp_pull: 8'h5A, ack_sda: 1'b0};
        tx_tab[1] = '{data: 8'h00, sda_en: 1'b1, exp_pull: 8'hFF, ack_sda: 1'b1};
        tx_tab[2] = '{data: 8'hFF, sda_en: 1'b1, exp_pull: 8'h00, ack_sda: 1'b0};
        tx_tab[3] = '{data: 8'h3C, sda_en: 1'b0, exp_pull: 8'h00, ack_sda: 1'b1};

        rx_tab[0] = '{pattern: 8'h3C, glitch: 8'h00, full: 1'b0, exp_data: 8'h3C, exp_push: 1, exp_ovf: 1'b0};
        rx_tab[1] = '{pattern: 8'hA5, glitch: 8'h00, full: 1'b0, exp_data: 8'hA5, exp_push: 1, exp_ovf: 1'b0};
        rx_tab[2] = '{pattern: 8'h81, glitch: 8'h00, full: 1'b1, exp_data: 8'h81, exp_push: 0, exp_ovf: 1'b1};
        rx_tab[3] = '{pattern: 8'h5A, glitch: 8'h00, full: 1'b0, exp_data: 8'h5A, exp_push: 1, exp_ovf: 1'b1};

        rst = 1'b1; slave_addr = 7'h00; rw = 1'b0; wa_en = 1'b0; wd_en = 1'b0;
        rx_en = 1'b0; sda_low_en = 1'b0; sda_en = 1'b1; scl = 1'b1; sda = 1'b1;
        tx_data = 8'h00; tx_empty = 1'b0; rx_full = 1'b0;
        repeat (3) tick();

        chk("rst_pull", sda_pull_low_o, 1'b0);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_ackv", ack_valid_o, 1'b0);
        chk("rst_underrun", underrun_o, 1'b0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_rx_data", rx_data_o, 8'h00);
        chk("rst_rx_wr", rx_wr_en_o, 1'b0);
        chk("rst_tx_rd", tx_rd_en_o, 1'b0);
        rst = 1'b0;
        tick();

        sda_low_en = 1'b1;
        tick();
        chk("force_low_on", sda_pull_low_o, 1'b1);
        sda_low_en = 1'b0;
        tick();
        chk("force_low_off", sda_pull_low_o, 1'b0);

        // Address 0x50 write: drive 1,0,1,0,0,0,0,0.
        slave_addr = 7'h50; rw = 1'b0;
        send_byte(1'b1, 1'b0, 8'h5F, 0, "addr50");
        ack_phase(1'b0, 1'b0, "addr50");

        for (int k = 0; k < 4; k++) begin
            tx_data = tx_tab[k].data;
            sda_en  = tx_tab[k].sda_en;
            send_byte(1'b0, 1'b0, tx_tab[k].exp_pull, 1, $sformatf("tx%0d", k));
            ack_phase(tx_tab[k].ack_sda, tx_tab[k].ack_sda, $sformatf("tx%0d", k));
        end
        sda_en = 1'b1;

        begin : underrun_seq
            int pops0;
            pops0 = tx_pops;
            tx_empty = 1'b1;
            wd_en = 1'b1;
            tick();
            wd_en = 1'b0;
            chk("underrun_flag", underrun_o, 1'b1);
            chk("underrun_released", sda_pull_low_o, 1'b0);
            tick();
            chk("underrun_no_pop", tx_pops - pops0, 0);
            tx_empty = 1'b0;
        end

        // Both enables together: address {0x2B,1}=0x57 wins, FIFO untouched.
        slave_addr = 7'h2B; rw = 1'b1; tx_data = 8'hFF;
        send_byte(1'b1, 1'b1, 8'hA8, 0, "prio");
        ack_phase(1'b1, 1'b1, "prio");
        chk("underrun_sticky", underrun_o, 1'b1);

        for (int k = 0; k < 4; k++) rx_byte(rx_tab[k], $sformatf("rx%0d", k));

`ifdef I2C_DP_SDA_FILTER_EN
        begin : glitch_seq
            rx_vec_t g;
            g = '{pattern: 8'h3C, glitch: 8'hFE, full: 1'b0, exp_data: 8'h3C, exp_push: 1, exp_ovf: 1'b1};
            rx_byte(g, "rx_glitch");
        end
`endif

        // Reset after the third address bit: {0x40,0} drives 1,0,0.
        slave_addr = 7'h40; rw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wa_en = 1'b1;
            tick();
            wa_en = 1'b0;
            tick();
        end
        chk("mid_pull_before_rst", sda_pull_low_o, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_pull", sda_pull_low_o, 1'b0);
        chk("mid_rst_underrun", underrun_o, 1'b0);
        chk("mid_rst_overflow", overflow_o, 1'b0);
        chk("mid_rst_rx_data", rx_data_o, 8'h00);
        chk("mid_rst_ack", ack_o, 1'b0);
        chk("mid_rst_ackv", ack_valid_o, 1'b0);
        chk("mid_rst_rx_wr", rx_wr_en_o, 1'b0);
        rst = 1'b0;
        repeat (LAT + 1) tick();

        slave_addr = 7'h50; rw = 1'b0;
        send_byte(1'b1, 1'b0, 8'h5F, 0, "post_rst");
        ack_phase(1'b0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
